// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the core's data-memory bus.
// The core stores bytes into a small TX FIFO through a 16-byte register window.
// A baud-timed FSM drains the FIFO and serialises each byte LSB first on tx.
// RD and hit are combinational from A; every other output comes from registered state.
`timescale 1ns/1ps

module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [3:0]  BE,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        hit,
    output logic        tx,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Transmitter state
    state_t         r_state;
    logic [15:0]    r_cnt;
    logic [15:0]    r_period;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_shift;
    logic           r_tx;

    // FIFO state
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_overflow;

    // Control register
    logic [15:0]    r_div;
    logic           r_ie;

    // Decode and handshake wires
    logic           w_hit;
    logic [1:0]     w_off;
    logic           w_full;
    logic           w_empty;
    logic           w_bit_end;
    logic           w_pop;
    logic           w_push_req;
    logic           w_push;
    logic           w_clr_ovf;
    logic           w_ctrl_wr;
    logic [31:0]    w_status;
    logic [31:0]    w_ctrl;
    logic [31:0]    w_rd_data;
    logic           w_unused;

    assign w_hit      = (A[31:4] == BASE_ADDR[31:4]);
    assign w_off      = A[3:2];
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == CW'(0));
    assign w_bit_end  = (r_cnt == r_period);

    // A store to TXDATA only pushes when the low byte lane is enabled.
    assign w_push_req = WE & w_hit & (w_off == 2'd0) & BE[0];
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_clr_ovf  = WE & w_hit & (w_off == 2'd1) & BE[0] & WD[3];
    assign w_ctrl_wr  = WE & w_hit & (w_off == 2'd2);

    // Address bits below the word, the top byte lane and unmapped data bits carry no meaning here.
    assign w_unused   = ^{A[1:0], BE[3], WD[31:17]};

    // The FSM consumes a byte when idle or at the end of a stop bit, provided one is queued.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = ~w_empty;
            S_STOP:  w_pop = w_bit_end & ~w_empty;
            default: w_pop = 1'b0;
        endcase
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end else if (w_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are don't-care while the pointers mark them empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= WD[7:0];
        end
    end

    // CTRL register, written lane by lane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= DEFAULT_DIV;
            r_ie  <= 1'b0;
        end else if (w_ctrl_wr) begin
            if (BE[0]) begin
                r_div[7:0] <= WD[7:0];
            end
            if (BE[1]) begin
                r_div[15:8] <= WD[15:8];
            end
            if (BE[2]) begin
                r_ie <= WD[16];
            end
        end
    end

    // Serialiser FSM: the bit period is latched at every bit start so a mid-bit
    // divisor change only affects the following bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_period  <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift  <= r_mem[r_rd_ptr];
                        r_cnt    <= 16'd0;
                        r_period <= r_div;
                        r_tx     <= 1'b0;
                        r_state  <= S_START;
                    end else begin
                        r_tx     <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= 16'd0;
                        r_period  <= r_div;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_cnt     <= r_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt    <= 16'd0;
                        r_period <= r_div;
                        r_shift  <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt    <= r_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt    <= 16'd0;
                        r_period <= r_div;
                        if (!w_empty) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt    <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // Register read mux; only STATUS and CTRL return data.
    always_comb begin
        w_status      = 32'd0;
        w_status[0]   = w_full;
        w_status[1]   = w_empty;
        w_status[2]   = (r_state != S_IDLE);
        w_status[3]   = r_overflow;
        w_status[8:4] = 5'(r_count);
        w_ctrl        = {15'd0, r_ie, r_div};
        w_rd_data     = 32'd0;
        if (w_hit) begin
            case (w_off)
                2'd1:    w_rd_data = w_status;
                2'd2:    w_rd_data = w_ctrl;
                default: w_rd_data = 32'd0;
            endcase
        end else begin
            w_rd_data = 32'd0;
        end
    end

    assign RD  = w_rd_data;
    assign hit = w_hit;
    assign tx  = r_tx;
    assign irq = r_ie & w_empty & (r_state == S_IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx. The line is checked sample by sample
// against a frame-level model: after the first store edge the line idles one
// cycle, then frames of 10*(DIV+1) cycles follow back to back.
`timescale 1ns/1ps

module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [3:0]  BE;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        hit;
    logic        tx;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model inputs: bytes expected on the line, in order, and the divisor.
    logic [7:0] m_bytes [16];
    int         m_n;
    int         m_div;

    mmio_uart_tx dut (
        .clk   (clk),
        .reset (reset),
        .WE    (WE),
        .BE    (BE),
        .A     (A),
        .WD    (WD),
        .RD    (RD),
        .hit   (hit),
        .tx    (tx),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Expected line level after edge e, counting the first store edge as e=1.
    function automatic logic exp_line(input int e);
        int t, fl, f, j;
        if (e < 2) return 1'b1;
        t  = e - 2;
        fl = 10 * (m_div + 1);
        f  = t / fl;
        j  = (t % fl) / (m_div + 1);
        if (f >= m_n) return 1'b1;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return m_bytes[f][j-1];
    endfunction

    // First edge index after which the line is idle again.
    function automatic int frames_end();
        return 2 + m_n * 10 * (m_div + 1);
    endfunction

    task automatic bus_idle();
        WE = 1'b0; BE = 4'd0; A = 32'd0; WD = 32'd0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        WE = 1'b1; A = addr; WD = data; BE = be;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_idle();
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx got %b exp 1", tx); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        A = BASE + 32'd4; #1;
        n_checks++; if (hit !== 1'b1) $display("FAIL reset_hit got %b exp 1", hit); else n_pass++;
        n_checks++; if (RD !== 32'h0000_0002) $display("FAIL reset_status got %h exp 00000002", RD); else n_pass++;
        A = BASE + 32'd8; #1;
        n_checks++; if (RD !== 32'h0000_01B1) $display("FAIL reset_ctrl got %h exp 000001b1", RD); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", irq); else n_pass++;
        bus_idle();
    endtask

    task automatic test_frame_a5();
        store(BASE + 32'd8, 32'd3, 4'b0011);
        m_div = 3; m_n = 1; m_bytes[0] = 8'hA5;
        for (int e = 0; e <= 45; e++) begin
            @(negedge clk);
            if (e >= 1) begin
                n_checks++;
                if (tx !== exp_line(e)) $display("FAIL a5_tx e=%0d got %b exp %b", e, tx, exp_line(e));
                else n_pass++;
            end
            bus_idle();
            if (e == 0) begin
                WE = 1'b1; A = BASE; WD = 32'h0000_00A5; BE = 4'b0001;
            end else if (e == 20) begin
                A = BASE + 32'd4; #1;
                n_checks++; if (RD[2] !== 1'b1) $display("FAIL a5_busy got %b exp 1", RD[2]); else n_pass++;
            end else if (e == 45) begin
                A = BASE + 32'd4; #1;
                n_checks++; if (RD !== 32'h0000_0002) $display("FAIL a5_done_status got %h exp 00000002", RD); else n_pass++;
            end
        end
        bus_idle();
    endtask

    task automatic test_random_frames();
        for (int it = 0; it < 4; it++) begin
            m_div = $urandom_range(0, 4);
            m_n   = $urandom_range(1, 3);
            for (int k = 0; k < m_n; k++) m_bytes[k] = 8'($urandom());
            store(BASE + 32'd8, 32'(m_div), 4'b0011);
            for (int e = 0; e <= frames_end() + 3; e++) begin
                @(negedge clk);
                if (e >= 1) begin
                    n_checks++;
                    if (tx !== exp_line(e)) $display("FAIL rand_tx it=%0d e=%0d got %b exp %b", it, e, tx, exp_line(e));
                    else n_pass++;
                end
                bus_idle();
                if (e < m_n) begin
                    WE = 1'b1; BE = 4'b1111;
                    A  = BASE | 32'($urandom_range(0, 3));
                    WD = {24'($urandom()), m_bytes[e]};
                end
            end
        end
        bus_idle();
    endtask

    task automatic test_overflow();
        logic [7:0] extra;
        store(BASE + 32'd8, 32'd0, 4'b0011);
        m_div = 0; m_n = 9;
        for (int k = 0; k < 9; k++) m_bytes[k] = 8'($urandom());
        extra = 8'($urandom());
        for (int e = 0; e <= frames_end() + 3; e++) begin
            @(negedge clk);
            if (e >= 1) begin
                n_checks++;
                if (tx !== exp_line(e)) $display("FAIL ovf_tx e=%0d got %b exp %b", e, tx, exp_line(e));
                else n_pass++;
            end
            bus_idle();
            if (e < 10) begin
                WE = 1'b1; A = BASE; BE = 4'b0001;
                WD = (e < 9) ? {24'd0, m_bytes[e]} : {24'd0, extra};
            end else if (e == 10) begin
                A = BASE + 32'd4; #1;
                n_checks++; if (RD !== 32'h0000_008D) $display("FAIL ovf_status got %h exp 0000008d", RD); else n_pass++;
            end else if (e == 11) begin
                WE = 1'b1; A = BASE + 32'd4; WD = 32'h0000_0008; BE = 4'b0001;
            end else if (e == 12) begin
                A = BASE + 32'd4; #1;
                n_checks++; if (RD !== 32'h0000_0074) $display("FAIL ovf_cleared got %h exp 00000074", RD); else n_pass++;
            end
        end
        bus_idle();
    endtask

    task automatic test_irq_back_to_back();
        store(BASE + 32'd8, 32'h0001_0001, 4'b0111);
        #1;
        n_checks++; if (irq !== 1'b1) $display("FAIL irq_idle got %b exp 1", irq); else n_pass++;
        m_div = 1; m_n = 2;
        for (int k = 0; k < 2; k++) m_bytes[k] = 8'($urandom());
        for (int e = 0; e <= frames_end() + 3; e++) begin
            @(negedge clk);
            if (e >= 1) begin
                n_checks++;
                if (tx !== exp_line(e)) $display("FAIL b2b_tx e=%0d got %b exp %b", e, tx, exp_line(e));
                else n_pass++;
                n_checks++;
                if (irq !== (e >= frames_end())) $display("FAIL b2b_irq e=%0d got %b exp %b", e, irq, (e >= frames_end()));
                else n_pass++;
            end
            bus_idle();
            if (e < 2) begin
                WE = 1'b1; A = BASE; WD = {24'd0, m_bytes[e]}; BE = 4'b0001;
            end
        end
        bus_idle();
    endtask

    task automatic test_reset_mid_frame();
        store(BASE + 32'd8, 32'h0001_0001, 4'b0111);
        m_div = 1; m_n = 3;
        for (int k = 0; k < 3; k++) m_bytes[k] = 8'($urandom());
        for (int e = 0; e <= 9; e++) begin
            @(negedge clk);
            if (e >= 1) begin
                n_checks++;
                if (tx !== exp_line(e)) $display("FAIL rmid_tx e=%0d got %b exp %b", e, tx, exp_line(e));
                else n_pass++;
            end
            bus_idle();
            if (e < 3) begin
                WE = 1'b1; A = BASE; WD = {24'd0, m_bytes[e]}; BE = 4'b0001;
            end
        end
        // Frame 1 is now in its data bits; reset must force the line high at once.
        reset = 1'b1; #1;
        n_checks++; if (tx !== 1'b1) $display("FAIL rmid_async_tx got %b exp 1", tx); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        A = BASE + 32'd4; #1;
        n_checks++; if (RD !== 32'h0000_0002) $display("FAIL rmid_status got %h exp 00000002", RD); else n_pass++;
        A = BASE + 32'd8; #1;
        n_checks++; if (RD !== 32'h0000_01B1) $display("FAIL rmid_ctrl got %h exp 000001b1", RD); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL rmid_irq got %b exp 0", irq); else n_pass++;
        bus_idle();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_checks++; if (tx !== 1'b1) $display("FAIL rmid_quiet c=%0d got %b exp 1", c, tx); else n_pass++;
        end
    endtask

    task automatic test_miss_and_div_change();
        logic [7:0] b;
        logic       ex;
        @(negedge clk);
        WE = 1'b1; A = BASE + 32'h10; WD = 32'h0000_00FF; BE = 4'b1111; #1;
        n_checks++; if (hit !== 1'b0) $display("FAIL miss_hit got %b exp 0", hit); else n_pass++;
        n_checks++; if (RD !== 32'd0) $display("FAIL miss_rd got %h exp 00000000", RD); else n_pass++;
        @(negedge clk);
        WE = 1'b1; A = BASE + 32'd1; WD = 32'h0000_5A00; BE = 4'b0010;
        @(negedge clk);
        bus_idle();
        A = BASE + 32'd4; #1;
        n_checks++; if (RD !== 32'h0000_0002) $display("FAIL miss_status got %h exp 00000002", RD); else n_pass++;
        n_checks++; if (tx !== 1'b1) $display("FAIL miss_tx got %b exp 1", tx); else n_pass++;
        A = BASE; #1;
        n_checks++; if (RD !== 32'd0) $display("FAIL txdata_read got %h exp 00000000", RD); else n_pass++;
        A = BASE + 32'd12; #1;
        n_checks++; if (RD !== 32'd0) $display("FAIL reserved_read got %h exp 00000000", RD); else n_pass++;
        bus_idle();
        store(BASE + 32'd8, 32'd3, 4'b0011);
        b = 8'($urandom());
        for (int e = 0; e <= 82; e++) begin
            @(negedge clk);
            if (e >= 1) begin
                // Start bit keeps the 4-cycle width, later bits take 8 cycles.
                if (e < 2)                ex = 1'b1;
                else if (e < 6)           ex = 1'b0;
                else if ((e - 6) / 8 < 8) ex = b[(e - 6) / 8];
                else                      ex = 1'b1;
                n_checks++;
                if (tx !== ex) $display("FAIL divchg_tx e=%0d got %b exp %b", e, tx, ex);
                else n_pass++;
            end
            bus_idle();
            if (e == 0) begin
                WE = 1'b1; A = BASE; WD = {24'd0, b}; BE = 4'b0001;
            end else if (e == 3) begin
                WE = 1'b1; A = BASE + 32'd8; WD = 32'd7; BE = 4'b0011;
            end
        end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_random_frames();
        test_overflow();
        test_irq_back_to_back();
        test_reset_mid_frame();
        test_miss_and_div_change();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
